// File: rtl/key_expansion_if.sv
// ---------------------------------------------------------------------------
// key_expansion_if
// Groups the control, key-load and round-key read signals of key_expansion.
//   start      : request to expand key_in (ignored while busy)
//   key_in     : 128-bit cipher key, byte 0 in [127:120]
//   busy       : expansion in progress
//   done       : one-cycle pulse when the last round key has been written
//   keys_valid : key store holds a complete schedule for the last accepted key
//   rk_addr    : round-key read index
//   rk_out     : registered read data for rk_addr (one cycle latency)
// master = requester side, slave = key_expansion side.
// ---------------------------------------------------------------------------
interface key_expansion_if;
  logic         start;
  logic [127:0] key_in;
  logic         busy;
  logic         done;
  logic         keys_valid;
  logic [3:0]   rk_addr;
  logic [127:0] rk_out;

  modport master (
    output start, key_in, rk_addr,
    input  busy, done, keys_valid, rk_out
  );

  modport slave (
    input  start, key_in, rk_addr,
    output busy, done, keys_valid, rk_out
  );
endinterface

// File: rtl/key_expansion.sv
// ---------------------------------------------------------------------------
// key_expansion
// Sequential AES-128 key schedule. One accepted cipher key is expanded into
// round keys 0..NR, one round key per clock, into an internal key store that
// is served through a registered random-access read port.
// Ports:
//   i_clk : single clock, rising edge
//   i_rst : synchronous active-high reset
//   bus   : key_expansion_if.slave (start/key_in/busy/done/keys_valid,
//           rk_addr/rk_out read port)
// Parameter NR (1..10): number of rounds; below 10 for reduced-round builds.
//
// sub_bytes (same file): byte-wise AES S-box over numbytes bytes, used here
// as SubWord with numbytes = 4.
// ---------------------------------------------------------------------------

module sub_bytes #(
  parameter int numbytes = 4
) (
  input  logic [8*numbytes-1:0] i_bytes,
  output logic [8*numbytes-1:0] o_bytes
);
  // FIPS-197 S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  genvar gi;
  generate
    for (gi = 0; gi < numbytes; gi++) begin : g_byte
      // Entry x sits at bit offset (255 - x) * 8 = {~x, 3'b000}.
      assign o_bytes[8*gi +: 8] = SBOX[{~i_bytes[8*gi +: 8], 3'b000} +: 8];
    end
  endgenerate
endmodule

module key_expansion #(
  parameter int NR = 10
) (
  input  logic          i_clk,
  input  logic          i_rst,
  key_expansion_if.slave bus
);
  localparam logic [3:0] NR_L = 4'(NR);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_EXPAND = 1'b1
  } state_t;

  state_t       r_state, w_state_next;
  logic [3:0]   r_cnt, w_cnt_next;
  logic [127:0] r_work, w_work_next;
  logic         r_done, w_done_next;
  logic         r_keys_valid, w_keys_valid_next;

  logic         w_we;
  logic [3:0]   w_waddr;
  logic [127:0] w_wdata;

  // Store depth is the full 4-bit address space so rk_addr indexes it
  // directly; only entries 0..NR are ever written.
  logic [127:0] r_store [16];
  logic [127:0] r_rk_out;

  // ---------------- next-round-key datapath ----------------
  logic [31:0]  w_w0, w_w1, w_w2, w_w3;
  logic [31:0]  w_rot, w_sub, w_temp;
  logic [31:0]  w_w4, w_w5, w_w6, w_w7;
  logic [127:0] w_next_key;
  logic [7:0]   w_rcon;

  assign {w_w0, w_w1, w_w2, w_w3} = r_work;
  assign w_rot = {w_w3[23:0], w_w3[31:24]};

  sub_bytes #(.numbytes(4)) u_sub_word (
    .i_bytes (w_rot),
    .o_bytes (w_sub)
  );

  // The counter equals the round number of the key being produced.
  always_comb begin
    w_rcon = 8'h00;
    case (r_cnt)
      4'd1:    w_rcon = 8'h01;
      4'd2:    w_rcon = 8'h02;
      4'd3:    w_rcon = 8'h04;
      4'd4:    w_rcon = 8'h08;
      4'd5:    w_rcon = 8'h10;
      4'd6:    w_rcon = 8'h20;
      4'd7:    w_rcon = 8'h40;
      4'd8:    w_rcon = 8'h80;
      4'd9:    w_rcon = 8'h1b;
      4'd10:   w_rcon = 8'h36;
      default: w_rcon = 8'h00;
    endcase
  end

  assign w_temp     = w_sub ^ {w_rcon, 24'h000000};
  assign w_w4       = w_w0 ^ w_temp;
  assign w_w5       = w_w4 ^ w_w1;
  assign w_w6       = w_w5 ^ w_w2;
  assign w_w7       = w_w6 ^ w_w3;
  assign w_next_key = {w_w4, w_w5, w_w6, w_w7};

  // ---------------- FSM ----------------
  always_comb begin
    w_state_next      = r_state;
    w_cnt_next        = r_cnt;
    w_work_next       = r_work;
    w_done_next       = 1'b0;
    w_keys_valid_next = r_keys_valid;
    w_we              = 1'b0;
    w_waddr           = r_cnt;
    w_wdata           = w_next_key;

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_next      = S_EXPAND;
          w_cnt_next        = 4'd1;
          w_work_next       = bus.key_in;
          w_keys_valid_next = 1'b0;
          w_we              = 1'b1;
          w_waddr           = 4'd0;
          w_wdata           = bus.key_in;
        end
      end
      S_EXPAND: begin
        w_we        = 1'b1;
        w_work_next = w_next_key;
        w_cnt_next  = r_cnt + 4'd1;
        if (r_cnt == NR_L) begin
          w_state_next      = S_IDLE;
          w_cnt_next        = 4'd0;
          w_done_next       = 1'b1;
          w_keys_valid_next = 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_work       <= 128'h0;
      r_done       <= 1'b0;
      r_keys_valid <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_work       <= w_work_next;
      r_done       <= w_done_next;
      r_keys_valid <= w_keys_valid_next;
    end
  end

  // ---------------- key store ----------------
  // Not reset; contents are meaningless until keys_valid is set.
  always_ff @(posedge i_clk) begin
    if (w_we && !i_rst) begin
      r_store[w_waddr] <= w_wdata;
    end
  end

  // Registered read: a same-edge write to the addressed entry is not seen
  // until the following edge (read-before-write).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rk_out <= 128'h0;
    end else if (bus.rk_addr <= NR_L) begin
      r_rk_out <= r_store[bus.rk_addr];
    end else begin
      r_rk_out <= 128'h0;
    end
  end

  assign bus.busy       = (r_state == S_EXPAND);
  assign bus.done       = r_done;
  assign bus.keys_valid = r_keys_valid;
  assign bus.rk_out     = r_rk_out;
endmodule

// File: tb/tb_key_expansion.sv
// ---------------------------------------------------------------------------
// tb_key_expansion
// Self-checking bench for key_expansion. Two instances share the clock:
// dut_a (NR = 10) and dut_b (NR = 2). The reference schedule is computed
// from the FIPS-197 word recurrence with an S-box derived from GF(2^8)
// inversion plus the affine map.
// ---------------------------------------------------------------------------
module tb_key_expansion;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  key_expansion_if bus_a ();
  key_expansion_if bus_b ();

  key_expansion #(.NR(10)) dut_a (.i_clk(clk), .i_rst(rst), .bus(bus_a));
  key_expansion #(.NR(2))  dut_b (.i_clk(clk), .i_rst(rst), .bus(bus_b));

  localparam logic [127:0] KEY_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  int checks = 0;
  int errors = 0;

  logic [7:0]   sbox_tab [256];
  logic [127:0] model_rk [11];
  logic [127:0] a1_rk    [11];
  logic [127:0] zero_rk  [11];

  // ---------------- reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] d;
    d = {b, b} << n;
    return d[15:8];
  endfunction

  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                  ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic model_expand(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]],
             sbox_tab[t[7:0]]} ^ {rc, 24'h000000};
        rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      model_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Ticks until dut_a.done is seen; n = edges after the accepting edge.
  task automatic wait_done_a(output int n);
    n = 0;
    while (n < 30 && bus_a.done !== 1'b1) begin
      tick();
      n++;
    end
  endtask

  task automatic sweep_a(input string tag);
    for (int a = 0; a < 11; a++) begin
      bus_a.rk_addr = 4'(a);
      tick();
      chk($sformatf("%s_rk%0d", tag, a), bus_a.rk_out, model_rk[a]);
    end
  endtask

  task automatic read_a(input int a, output logic [127:0] d);
    bus_a.rk_addr = 4'(a);
    tick();
    d = bus_a.rk_out;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int seen;
    logic [127:0] d;
    logic [127:0] rnd;

    bus_a.start = 1'b0; bus_a.key_in = '0; bus_a.rk_addr = '0;
    bus_b.start = 1'b0; bus_b.key_in = '0; bus_b.rk_addr = '0;
    build_sbox();
    model_expand(128'h0);
    zero_rk = model_rk;
    model_expand(KEY_A1);
    a1_rk = model_rk;

    // Reset state
    repeat (3) tick();
    chk("rst_busy", bus_a.busy, 1'b0);
    chk("rst_done", bus_a.done, 1'b0);
    chk("rst_kv", bus_a.keys_valid, 1'b0);
    chk("rst_rk_out", bus_a.rk_out, 128'h0);
    rst = 1'b0;
    tick();

    // FIPS-197 A.1 key, basic run
    bus_a.key_in = KEY_A1; bus_a.start = 1'b1;
    tick();
    bus_a.start = 1'b0;
    chk("a1_busy_after_accept", bus_a.busy, 1'b1);
    chk("a1_kv_after_accept", bus_a.keys_valid, 1'b0);
    wait_done_a(n);
    chk("a1_latency", 128'(n), 128'd10);
    chk("a1_kv_at_done", bus_a.keys_valid, 1'b1);
    chk("a1_busy_at_done", bus_a.busy, 1'b0);
    tick();
    chk("a1_done_pulse_width", bus_a.done, 1'b0);
    model_rk = a1_rk;
    sweep_a("a1");
    read_a(1, d);  chk("a1_fips_rk1", d, 128'ha0fafe1788542cb123a339392a6c7605);
    read_a(10, d); chk("a1_fips_rk10", d, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    for (int a = 11; a < 16; a++) begin
      read_a(a, d);
      chk($sformatf("oob_addr%0d", a), d, 128'h0);
    end

    // Start held while busy, then accepted in the done cycle with zero key.
    // Each cycle reads back the key written on the previous edge.
    rnd = {$urandom, $urandom, $urandom, $urandom};
    bus_a.key_in = KEY_A1; bus_a.start = 1'b1;
    tick();
    for (int c = 1; c <= 10; c++) begin
      bus_a.start   = (c >= 3);
      bus_a.key_in  = (c <= 8) ? rnd : 128'h0;
      bus_a.rk_addr = 4'(c - 1);
      tick();
      chk($sformatf("busy_start_rb_rk%0d", c - 1), bus_a.rk_out, a1_rk[c-1]);
    end
    chk("busy_start_done", bus_a.done, 1'b1);
    bus_a.start = 1'b1; bus_a.key_in = 128'h0; bus_a.rk_addr = 4'd10;
    tick();
    bus_a.start = 1'b0;
    chk("busy_start_rb_rk10", bus_a.rk_out, a1_rk[10]);
    chk("done_cycle_accept_busy", bus_a.busy, 1'b1);
    chk("done_cycle_accept_kv", bus_a.keys_valid, 1'b0);
    repeat (3) tick();
    chk("zero_kv_mid", bus_a.keys_valid, 1'b0);
    wait_done_a(n);
    chk("zero_latency_rest", 128'(n), 128'd7);
    model_rk = zero_rk;
    sweep_a("zero");
    read_a(0, d);  chk("zero_fips_rk0", d, 128'h0);
    read_a(1, d);  chk("zero_fips_rk1", d, 128'h62636363626363636263636362636363);
    read_a(2, d);  chk("zero_fips_rk2", d, 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa);
    read_a(10, d); chk("zero_fips_rk10", d, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    // Read-before-write on index 4 (store holds the zero-key schedule)
    bus_a.key_in = KEY_A1; bus_a.start = 1'b1; bus_a.rk_addr = 4'd4;
    tick();
    bus_a.start = 1'b0;
    repeat (3) tick();
    tick();
    chk("rbw_old", bus_a.rk_out, zero_rk[4]);
    tick();
    chk("rbw_new", bus_a.rk_out, a1_rk[4]);
    wait_done_a(n);
    chk("rbw_latency_rest", 128'(n), 128'd5);

    // Reset in the middle of an expansion
    bus_a.key_in = KEY_A1; bus_a.start = 1'b1; bus_a.rk_addr = 4'd3;
    tick();
    bus_a.start = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    chk("midrst_busy", bus_a.busy, 1'b0);
    chk("midrst_done", bus_a.done, 1'b0);
    chk("midrst_kv", bus_a.keys_valid, 1'b0);
    chk("midrst_rk_out", bus_a.rk_out, 128'h0);
    rst = 1'b0;
    seen = 0;
    repeat (15) begin
      tick();
      if (bus_a.done === 1'b1) seen++;
    end
    chk("midrst_no_done", 128'(seen), 128'd0);
    chk("midrst_kv_stays0", bus_a.keys_valid, 1'b0);

    // Randomised keys against the model (first one follows the reset)
    for (int k = 0; k < 4; k++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      model_expand(rnd);
      bus_a.key_in = rnd; bus_a.start = 1'b1;
      tick();
      bus_a.start = 1'b0;
      wait_done_a(n);
      chk($sformatf("rand%0d_latency", k), 128'(n), 128'd10);
      chk($sformatf("rand%0d_kv", k), bus_a.keys_valid, 1'b1);
      sweep_a($sformatf("rand%0d", k));
    end

    // Reduced-round build, NR = 2
    bus_b.key_in = KEY_A1; bus_b.start = 1'b1;
    tick();
    bus_b.start = 1'b0;
    n = 0;
    while (n < 30 && bus_b.done !== 1'b1) begin
      tick();
      n++;
    end
    chk("nr2_latency", 128'(n), 128'd2);
    chk("nr2_kv", bus_b.keys_valid, 1'b1);
    for (int a = 0; a < 3; a++) begin
      bus_b.rk_addr = 4'(a);
      tick();
      chk($sformatf("nr2_rk%0d", a), bus_b.rk_out, a1_rk[a]);
    end
    chk("nr2_fips_rk2", bus_b.rk_out, 128'hf2c295f27a96b9435935807a7359f67f);
    bus_b.rk_addr = 4'd3;
    tick();
    chk("nr2_oob_addr3", bus_b.rk_out, 128'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no completion, expected finish before time limit");
    $fatal(1, "simulation time limit reached");
  end
endmodule
